moore_seq_detector: RTL

- Parametrised Moore sequence detector; generalises the two-state Moore FSM.
- Pattern width, pattern value and overlap mode are elaboration-time parameters.
- Serial input `din` is sampled MSB-of-pattern first.
- `dout` is a registered Moore output. The current state is exported for debug and bench visibility.
- Used as a reusable serial pattern/frame-marker detector in the FSM library.

---
 rtl/seq_det_pkg.sv | 83 ++++++++
 rtl/seq_next_state.sv | 30 +++
 rtl/moore_seq_detector.sv | 68 ++++++
 3 files changed

// File: rtl/seq_det_pkg.sv
// Shared definitions for the parametrised Moore sequence detector.
//   state_w()           : state register width for a given pattern length
//   build_next_table()  : next-state lookup table built at elaboration
//                         (match advance + KMP fallback + post-match restart)
//   S_IDLE              : index of the "nothing matched" state
// Table layout: one ENT_W-bit entry per (state, din), at bit offset
// ({state, din}) * ENT_W, covering states 0..MAX_SEQ_W.
package seq_det_pkg;

  localparam int S_IDLE    = 0;
  localparam int MAX_SEQ_W = 16;
  localparam int ENT_W     = 5;
  localparam int TBL_W     = (MAX_SEQ_W + 1) * 2 * ENT_W;

  function automatic int state_w(input int seq_w);
    return $clog2(seq_w + 1);
  endfunction

  // Pattern bit i in arrival order (i = 0 is the first bit on din).
  function automatic logic pat_bit(input logic [MAX_SEQ_W-1:0] seq,
                                   input int seq_w, input int i);
    return seq[seq_w-1-i];
  endfunction

  // Longest pattern prefix that is a suffix of (first k pattern bits, d).
  // When d continues the pattern this naturally yields k+1.
  function automatic int longest_fallback(input logic [MAX_SEQ_W-1:0] seq,
                                          input int seq_w, input int k,
                                          input logic d);
    int   best;
    int   s_idx;
    logic ok;
    logic sb;
    best = 0;
    for (int len = 1; len <= k + 1; len++) begin
      ok = 1'b1;
      for (int j = 0; j < len; j++) begin
        s_idx = k + 1 - len + j;
        sb    = (s_idx == k) ? d : pat_bit(seq, seq_w, s_idx);
        if (pat_bit(seq, seq_w, j) != sb) ok = 1'b0;
      end
      if (ok) best = len;
    end
    return best;
  endfunction

  // Longest proper border: prefix of length < seq_w equal to a suffix.
  function automatic int longest_border(input logic [MAX_SEQ_W-1:0] seq,
                                        input int seq_w);
    int   best;
    logic ok;
    best = 0;
    for (int len = 1; len < seq_w; len++) begin
      ok = 1'b1;
      for (int j = 0; j < len; j++) begin
        if (pat_bit(seq, seq_w, j) != pat_bit(seq, seq_w, seq_w - len + j)) ok = 1'b0;
      end
      if (ok) best = len;
    end
    return best;
  endfunction

  function automatic logic [TBL_W-1:0] build_next_table(input logic [MAX_SEQ_W-1:0] seq,
                                                        input int seq_w,
                                                        input int overlap);
    logic [TBL_W-1:0] tbl;
    int               src;
    tbl = '0;
    for (int k = 0; k < seq_w; k++) begin
      for (int d = 0; d < 2; d++) begin
        tbl[(k*2+d)*ENT_W +: ENT_W] = ENT_W'(longest_fallback(seq, seq_w, k, 1'(d)));
      end
    end
    // The match state behaves like the border state (overlap) or like S0
    // (restart) for the bit that follows it.
    src = (overlap != 0) ? longest_border(seq, seq_w) : S_IDLE;
    for (int d = 0; d < 2; d++) begin
      tbl[(seq_w*2+d)*ENT_W +: ENT_W] = tbl[(src*2+d)*ENT_W +: ENT_W];
    end
    return tbl;
  endfunction

endpackage

// File: rtl/seq_next_state.sv
// Combinational next-state lookup for the Moore sequence detector.
// Ports:
//   state      : current state index
//   din        : serial data bit being sampled
//   next_state : state after consuming din
// Encodings above SEQ_W are unreachable; they map to S_IDLE.
module seq_next_state
  import seq_det_pkg::*;
#(
  parameter int             SEQ_W   = 4,
  parameter logic [SEQ_W-1:0] SEQ   = 4'b1011,
  parameter int             OVERLAP = 1
) (
  input  logic [state_w(SEQ_W)-1:0] state,
  input  logic                      din,
  output logic [state_w(SEQ_W)-1:0] next_state
);

  localparam int               SW       = state_w(SEQ_W);
  localparam logic [SW-1:0]    S_MATCH  = SW'(SEQ_W);
  localparam logic [TBL_W-1:0] NEXT_TBL = build_next_table(MAX_SEQ_W'(SEQ), SEQ_W, OVERLAP);

  always_comb begin
    next_state = SW'(S_IDLE);
    if (state <= S_MATCH) begin
      next_state = SW'(NEXT_TBL[{state, din} * ENT_W +: ENT_W]);
    end
  end

endmodule

// File: rtl/moore_seq_detector.sv
// Parametrised Moore serial pattern detector (pattern MSB arrives first).
// Ports:
//   clk       : rising-edge clock
//   rst       : synchronous active-high reset (dominates en)
//   en        : sample enable; din is consumed only when high
//   din       : serial data bit
//   dout      : high while the detector sits in the match state S[SEQ_W]
//   state     : current state index (debug visibility)
//   match_cnt : saturating count of entries into the match state
// Build option: MOORE_SEQ_DET_COUNT_EN includes the match counter; without
// it match_cnt is tied to zero and no counter flops exist.
module moore_seq_detector
  import seq_det_pkg::*;
#(
  parameter int               SEQ_W   = 4,
  parameter logic [SEQ_W-1:0] SEQ     = 4'b1011,
  parameter int               OVERLAP = 1,
  parameter int               CNT_W   = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  input  logic                      din,
  output logic                      dout,
  output logic [state_w(SEQ_W)-1:0] state,
  output logic [CNT_W-1:0]          match_cnt
);

  localparam int            SW      = state_w(SEQ_W);
  localparam logic [SW-1:0] S_MATCH = SW'(SEQ_W);

  logic [SW-1:0] next_state;

  seq_next_state #(
    .SEQ_W  (SEQ_W),
    .SEQ    (SEQ),
    .OVERLAP(OVERLAP)
  ) u_next (
    .state     (state),
    .din       (din),
    .next_state(next_state)
  );

  // dout is registered in lockstep with state so it always equals
  // (state == S_MATCH) without a decode after the flop.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= SW'(S_IDLE);
      dout  <= 1'b0;
    end else if (en) begin
      state <= next_state;
      dout  <= (next_state == S_MATCH);
    end
  end

`ifdef MOORE_SEQ_DET_COUNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      match_cnt <= '0;
    end else if (en && (next_state == S_MATCH) && (match_cnt != '1)) begin
      match_cnt <= match_cnt + CNT_W'(1);
    end
  end
`else
  assign match_cnt = '0;
`endif

endmodule
